// File: rtl/snes_load_pkg.sv
// Shared definitions for the ROM loader: FSM state encoding, header field
// offsets, the default header length and the size-to-mask helper.
package snes_load_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam int HDR_BYTES_DEF = 64;

    // Byte offsets of the fields inside the image header
    localparam int SIZE_OFS = 0;   // 24-bit payload size, little-endian
    localparam int TYPE_OFS = 4;   // map control byte
    localparam int CSUM_OFS = 6;   // 16-bit payload checksum, little-endian

    // Smallest 2^n-1 that covers every byte offset of an image of 'size' bytes.
    // Smearing the top set bit of (size-1) downwards yields exactly that mask.
    function automatic logic [23:0] size_to_mask(input logic [23:0] size);
        logic [23:0] m;
        if (size == 24'd0) begin
            return 24'd0;
        end
        m = size - 24'd1;
        for (int s = 1; s < 24; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

endpackage

// File: rtl/load_word_fifo.sv
// Synchronous word FIFO between the byte packer and the SDRAM handshake.
// A push and a pop in the same cycle are both performed, so a full FIFO can
// still take a word while its head is being retired.
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   push, push_data  write strobe and 16-bit word
//   pop              retire the head entry
//   head             current head entry (valid while !empty)
//   full, empty      occupancy flags
//   count            number of stored words
module load_word_fifo #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [15:0]      push_data,
    input  logic             pop,
    output logic [15:0]      head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM load controller: takes the loader byte stream, captures the image
// header, packs payload bytes into 16-bit words and writes them to SDRAM via
// a req/ack handshake. Reports size, map type, address mask, done and fail.
// Optional feature macro: ROM_CHECKSUM_EN (payload checksum against header).
// Ports:
//   clk, resetn     clock and synchronous active-low reset
//   in_data         stream byte
//   in_valid        one-cycle byte strobe, no backpressure
//   in_loading      high while the source still has bytes to send
//   mem_req         write request, held until mem_ack
//   mem_addr        word address, 0 at the first payload word
//   mem_din         {odd byte, even byte}
//   mem_ack         one-cycle strobe: current word written
//   rom_size        payload size in bytes (header bytes 0..2)
//   rom_type        header byte 4
//   rom_mask        2^n-1 covering rom_size
//   busy            loading in progress (HEADER, DATA, FLUSH)
//   done, fail      sticky completion / abort flags
module rom_load_ctrl
    import snes_load_pkg::*;
#(
    parameter int HDR_BYTES  = HDR_BYTES_DEF,
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_loading,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic [23:0]       rom_size,
    output logic [7:0]        rom_type,
    output logic [23:0]       rom_mask,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam int IDX_W = $clog2(HDR_BYTES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    typedef logic [IDX_W-1:0] idx_t;

    state_t            state_q, state_d;
    idx_t              hdr_cnt_q, hdr_cnt_d;
    logic [23:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic [23:0]       size_q, size_d;
    logic [7:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;

    logic              push;
    logic [15:0]       push_data;
    logic              pop;
    logic [15:0]       head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    idx_t              hdr_idx;
    logic              hdr_take;
    logic              addr_wrap;
    logic              pad_pending;
    logic              csum_ok;

`ifdef ROM_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
    logic [15:0]       hdr_csum_q, hdr_csum_d;
    assign csum_ok = (csum_q == hdr_csum_q);
`else
    assign csum_ok = 1'b1;
`endif

    load_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Memory handshake. The head word stays in the FIFO until acknowledged, so
    // the FIFO depth bounds the number of unacknowledged words.
    assign pop       = req_q && mem_ack;
    assign addr_d    = pop ? addr_q + ADDR_W'(1) : addr_q;
    assign addr_wrap = pop && (addr_q == '1);
    // After a pop, keep requesting if a word remains, including one being
    // pushed this cycle; otherwise request one cycle after data appears.
    assign req_d     = pop ? ((count > CNT_W'(1)) || push) : (req_q || !empty);

    // The first header byte arrives while still in IDLE.
    assign hdr_idx  = (state_q == IDLE) ? '0 : hdr_cnt_q;
    assign hdr_take = in_valid && ((state_q == IDLE) || (state_q == HEADER));

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        lo_d        = lo_q;
        size_d      = size_q;
        type_d      = type_q;
        push        = 1'b0;
        push_data   = 16'h0000;
        pad_pending = 1'b0;
`ifdef ROM_CHECKSUM_EN
        csum_d      = csum_q;
        hdr_csum_d  = hdr_csum_q;
`endif

        if (hdr_take) begin
            hdr_cnt_d = hdr_idx + idx_t'(1);
            if (hdr_idx == idx_t'(SIZE_OFS))     size_d[7:0]   = in_data;
            if (hdr_idx == idx_t'(SIZE_OFS + 1)) size_d[15:8]  = in_data;
            if (hdr_idx == idx_t'(SIZE_OFS + 2)) size_d[23:16] = in_data;
            if (hdr_idx == idx_t'(TYPE_OFS))     type_d        = in_data;
`ifdef ROM_CHECKSUM_EN
            if (hdr_idx == idx_t'(CSUM_OFS))     hdr_csum_d[7:0]  = in_data;
            if (hdr_idx == idx_t'(CSUM_OFS + 1)) hdr_csum_d[15:8] = in_data;
`endif
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = HEADER;
                end
            end

            HEADER: begin
                if (in_valid && (hdr_cnt_q == idx_t'(HDR_BYTES - 1))) begin
                    state_d = DATA;
                end else if (!in_loading) begin
                    state_d = FAIL;
                end
            end

            DATA: begin
                if (in_valid) begin
                    byte_cnt_d = byte_cnt_q + 24'd1;
`ifdef ROM_CHECKSUM_EN
                    csum_d = csum_q + {8'h00, in_data};
`endif
                    if (!byte_cnt_q[0]) begin
                        lo_d = in_data;
                    end else begin
                        push      = 1'b1;
                        push_data = {in_data, lo_q};
                    end
                end
                if (!in_loading) begin
                    // A byte arriving with the in_loading fall is counted
                    // first; an unpaired even byte is flushed zero-padded.
                    pad_pending = in_valid ? !byte_cnt_q[0] : byte_cnt_q[0];
                    if (pad_pending) begin
                        push      = 1'b1;
                        push_data = {8'h00, in_valid ? in_data : lo_q};
                    end
                end

                if ((in_valid && (byte_cnt_q == '1)) ||
                    (push && full && !pop) || addr_wrap) begin
                    state_d = FAIL;
                end else if (!in_loading) begin
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                if (empty && !req_q) begin
                    state_d = ((byte_cnt_q == size_q) && csum_ok) ? DONE : FAIL;
                end
            end

            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= '0;
            byte_cnt_q <= '0;
            lo_q       <= '0;
            size_q     <= '0;
            type_q     <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            csum_q     <= '0;
            hdr_csum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            lo_q       <= lo_d;
            size_q     <= size_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
`ifdef ROM_CHECKSUM_EN
            csum_q     <= csum_d;
            hdr_csum_q <= hdr_csum_d;
`endif
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    // Gated so the bus reads zero whenever no write is being requested.
    assign mem_din  = req_q ? head : 16'h0000;
    assign rom_size = size_q;
    assign rom_type = type_q;
    assign rom_mask = size_to_mask(size_q);
    assign busy     = (state_q == HEADER) || (state_q == DATA) || (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign fail     = (state_q == FAIL);

endmodule
